prf_recovery_ctrl: RTL and testbench

Recovery sequencer for the physical-register free list on branch misprediction. It keeps an in-order journal of the destination tags allocated at dispatch and retires journal entries at commit. On `prmiss` it walks the journal backwards from the youngest entry to the mispredicted branch and returns each squashed tag to the free list, at most two per cycle. Dispatch is stalled for the whole walk.

---
 rtl/prf_recovery_ctrl_pkg.sv | 15 +
 rtl/prf_recovery_ctrl_journal.sv | 54 +++++
 rtl/prf_recovery_ctrl.sv | 173 +++++++++++++++++
 tb/tb_prf_recovery_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/prf_recovery_ctrl_pkg.sv
// Shared constants and types for the free-list recovery sequencer.
//   PHY_REG_SEL : width of a physical register tag
//   JRNL_DEPTH  : default journal depth (one entry per ROB slot)
//   rec_state_e : recovery FSM encoding
package prf_recovery_ctrl_pkg;

   localparam int PHY_REG_SEL = 6;
   localparam int JRNL_DEPTH  = 32;

   typedef enum logic [0:0] {
      REC_IDLE = 1'b0,
      REC_WALK = 1'b1
   } rec_state_e;

endpackage

// File: rtl/prf_recovery_ctrl_journal.sv
// recovery_journal: circular journal of {val, tag} entries.
// Two synchronous write ports (dispatch slots 1/2) and two asynchronous
// read ports (youngest two entries during a walk).
//   clk, reset        : clock, async active-low reset (clears vals only)
//   we*/wa*/wv*/wt*   : write enable, index, val bit, tag
//   ra*/rv*/rt*       : read index, val bit, tag
module recovery_journal
   import prf_recovery_ctrl_pkg::*;
#(
   parameter int DEPTH = JRNL_DEPTH,
   parameter int PTR_W = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   we1,
   input  logic [PTR_W-1:0]       wa1,
   input  logic                   wv1,
   input  logic [PHY_REG_SEL-1:0] wt1,
   input  logic                   we2,
   input  logic [PTR_W-1:0]       wa2,
   input  logic                   wv2,
   input  logic [PHY_REG_SEL-1:0] wt2,
   input  logic [PTR_W-1:0]       ra1,
   output logic                   rv1,
   output logic [PHY_REG_SEL-1:0] rt1,
   input  logic [PTR_W-1:0]       ra2,
   output logic                   rv2,
   output logic [PHY_REG_SEL-1:0] rt2
);

   logic [DEPTH-1:0]       val_q;
   logic [PHY_REG_SEL-1:0] tag_q [DEPTH];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         val_q <= '0;
      end else begin
         if (we1) val_q[wa1] <= wv1;
         if (we2) val_q[wa2] <= wv2;
      end
   end

   // Tags need no reset: a tag is only ever read alongside its val bit.
   always_ff @(posedge clk) begin
      if (we1) tag_q[wa1] <= wt1;
      if (we2) tag_q[wa2] <= wt2;
   end

   assign rv1 = val_q[ra1];
   assign rt1 = tag_q[ra1];
   assign rv2 = val_q[ra2];
   assign rt2 = tag_q[ra2];

endmodule

// File: rtl/prf_recovery_ctrl.sv
// Free-list recovery sequencer. Journals destination tags at dispatch,
// retires them at commit, and on a misprediction walks the journal from
// the youngest entry back to the branch, returning up to two tags/cycle.
//   clk, reset              : clock, async active-low reset
//   dp_num, dp_dst*_val/dst*: dispatch count and allocated tags
//   comnum                  : commit count
//   prmiss, prmiss_ptr      : misprediction pulse and branch journal pointer
//   dp_ptr                  : pointer the next dispatched instruction gets
//   rec_tag*, rec_tag*_val  : tags returned to the free list (registered)
//   recovering              : walk in progress, dispatch must stall
//   jfull                   : fewer than two free journal entries
//
// state    | meaning
// REC_IDLE | journal tracks dispatch/commit; prmiss starts a walk
// REC_WALK | popping squashed entries from tail down to tgt
module prf_recovery_ctrl
   import prf_recovery_ctrl_pkg::*;
#(
   parameter int DEPTH = JRNL_DEPTH,
   parameter int PTR_W = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [1:0]             dp_num,
   input  logic                   dp_dst1_val,
   input  logic                   dp_dst2_val,
   input  logic [PHY_REG_SEL-1:0] dp_dst1,
   input  logic [PHY_REG_SEL-1:0] dp_dst2,
   input  logic [1:0]             comnum,
   input  logic                   prmiss,
   input  logic [PTR_W:0]         prmiss_ptr,
   output logic [PTR_W:0]         dp_ptr,
   output logic [PHY_REG_SEL-1:0] rec_tag1,
   output logic [PHY_REG_SEL-1:0] rec_tag2,
   output logic                   rec_tag1_val,
   output logic                   rec_tag2_val,
   output logic                   recovering,
   output logic                   jfull
);

   localparam logic [PTR_W:0]   PTR_ONE = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   PTR_TWO = (PTR_W+1)'(2);
   localparam logic [PTR_W-1:0] IDX_ONE = PTR_W'(1);
   localparam logic [PTR_W-1:0] IDX_TWO = PTR_W'(2);
   localparam logic [PTR_W:0]   FULL_TH = (PTR_W+1)'(DEPTH - 2);

   rec_state_e state_q, state_nxt;

   logic [PTR_W:0] head_q, tail_q, tgt_q;
   logic [PTR_W:0] tail_nxt, tgt_nxt, prmiss_tgt;
   logic [PTR_W:0] disp_n, com_n, walk_n, cnt;
   logic           take1, take2, prmiss_older;

   logic                   we1, we2;
   logic                   rv1, rv2;
   logic [PHY_REG_SEL-1:0] rt1, rt2;

   logic                   rec_val1_d, rec_val2_d;
   logic [PHY_REG_SEL-1:0] rec_tag1_d, rec_tag2_d;

   // dp_num = 3 is out of protocol; clamp so the journal stays consistent.
   assign disp_n = (dp_num == 2'd3) ? PTR_TWO : (PTR_W+1)'(dp_num);
   assign com_n  = (PTR_W+1)'(comnum);

   assign take1  = (tail_q != tgt_q);
   assign take2  = take1 && ((tail_q - PTR_ONE) != tgt_q);
   assign walk_n = take2 ? PTR_TWO : (take1 ? PTR_ONE : '0);

   assign prmiss_tgt = prmiss_ptr + PTR_ONE;
   // Distances from head order branches correctly across pointer wrap.
   assign prmiss_older = (prmiss_ptr - head_q) < (tgt_q - PTR_ONE - head_q);

   assign cnt = tail_q - head_q;

   recovery_journal #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_journal (
      .clk   (clk),
      .reset (reset),
      .we1   (we1),
      .wa1   (tail_q[PTR_W-1:0]),
      .wv1   (dp_dst1_val),
      .wt1   (dp_dst1),
      .we2   (we2),
      .wa2   (tail_q[PTR_W-1:0] + IDX_ONE),
      .wv2   (dp_dst2_val),
      .wt2   (dp_dst2),
      .ra1   (tail_q[PTR_W-1:0] - IDX_ONE),
      .rv1   (rv1),
      .rt1   (rt1),
      .ra2   (tail_q[PTR_W-1:0] - IDX_TWO),
      .rv2   (rv2),
      .rt2   (rt2)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= REC_IDLE;
      else        state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      tail_nxt  = tail_q;
      tgt_nxt   = tgt_q;
      unique case (state_q)
         REC_IDLE: begin
            if (prmiss) begin
               tgt_nxt   = prmiss_tgt;
               state_nxt = REC_WALK;
            end else begin
               tail_nxt = tail_q + disp_n;
            end
         end
         REC_WALK: begin
            tail_nxt = tail_q - walk_n;
            // An accepted older branch moves tgt strictly below the current
            // one, so the walk can never finish in the same cycle.
            if (prmiss && prmiss_older) tgt_nxt = prmiss_tgt;
            else if (tail_nxt == tgt_q) state_nxt = REC_IDLE;
         end
         default: state_nxt = REC_IDLE;
      endcase
   end

   always_comb begin
      we1        = 1'b0;
      we2        = 1'b0;
      rec_tag1_d = '0;
      rec_tag2_d = '0;
      rec_val1_d = 1'b0;
      rec_val2_d = 1'b0;
      unique case (state_q)
         REC_IDLE: begin
            we1 = !prmiss && (disp_n != '0);
            we2 = !prmiss && (disp_n == PTR_TWO);
         end
         REC_WALK: begin
            if (take1) begin
               rec_tag1_d = rt1;
               rec_val1_d = rv1;
            end
            if (take2) begin
               rec_tag2_d = rt2;
               rec_val2_d = rv2;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q       <= '0;
         tail_q       <= '0;
         tgt_q        <= '0;
         rec_tag1     <= '0;
         rec_tag2     <= '0;
         rec_tag1_val <= 1'b0;
         rec_tag2_val <= 1'b0;
      end else begin
         head_q       <= head_q + com_n;
         tail_q       <= tail_nxt;
         tgt_q        <= tgt_nxt;
         rec_tag1     <= rec_tag1_d;
         rec_tag2     <= rec_tag2_d;
         rec_tag1_val <= rec_val1_d;
         rec_tag2_val <= rec_val2_d;
      end
   end

   assign dp_ptr     = tail_q;
   assign recovering = (state_q == REC_WALK);
   assign jfull      = (cnt > FULL_TH);

endmodule

// File: tb/tb_prf_recovery_ctrl.sv
module tb_prf_recovery_ctrl;
   import prf_recovery_ctrl_pkg::*;

   localparam int DEPTH = 32;
   localparam int PTR_W = 5;

   logic                   clk = 1'b0;
   logic                   reset = 1'b0;
   logic [1:0]             dp_num = '0;
   logic                   dp_dst1_val = 1'b0, dp_dst2_val = 1'b0;
   logic [PHY_REG_SEL-1:0] dp_dst1 = '0, dp_dst2 = '0;
   logic [1:0]             comnum = '0;
   logic                   prmiss = 1'b0;
   logic [PTR_W:0]         prmiss_ptr = '0;
   logic [PTR_W:0]         dp_ptr;
   logic [PHY_REG_SEL-1:0] rec_tag1, rec_tag2;
   logic                   rec_tag1_val, rec_tag2_val, recovering, jfull;

   prf_recovery_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk(clk), .reset(reset), .dp_num(dp_num),
      .dp_dst1_val(dp_dst1_val), .dp_dst2_val(dp_dst2_val),
      .dp_dst1(dp_dst1), .dp_dst2(dp_dst2), .comnum(comnum),
      .prmiss(prmiss), .prmiss_ptr(prmiss_ptr), .dp_ptr(dp_ptr),
      .rec_tag1(rec_tag1), .rec_tag2(rec_tag2),
      .rec_tag1_val(rec_tag1_val), .rec_tag2_val(rec_tag2_val),
      .recovering(recovering), .jfull(jfull)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [PHY_REG_SEL-1:0] t1;
      logic                   v1;
      logic [PHY_REG_SEL-1:0] t2;
      logic                   v2;
   } rec_t;

   rec_t                   sb_q[$];
   logic [PHY_REG_SEL-1:0] m_tag [DEPTH];
   logic                   m_val [DEPTH];
   logic [PTR_W:0]         m_head = '0, m_tail = '0;
   int                     n_cmp = 0;
   int                     n_err = 0;

   // Protocol guard: no dispatch while recovering or when the journal is full.
   always @(posedge clk) begin
      if (reset && dp_num != 2'd0 && (recovering || jfull)) begin
         n_err++;
         $error("FAIL illegal_dispatch recovering=%0b jfull=%0b dp_num=%0d", recovering, jfull, dp_num);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic disp(input int n, input logic [PHY_REG_SEL-1:0] t1, input logic v1,
                       input logic [PHY_REG_SEL-1:0] t2, input logic v2, input int cm);
      dp_num = 2'(n); dp_dst1 = t1; dp_dst1_val = v1; dp_dst2 = t2; dp_dst2_val = v2;
      comnum = 2'(cm);
      if (n >= 1) begin m_tag[m_tail[PTR_W-1:0]] = t1; m_val[m_tail[PTR_W-1:0]] = v1; m_tail++; end
      if (n == 2) begin m_tag[m_tail[PTR_W-1:0]] = t2; m_val[m_tail[PTR_W-1:0]] = v2; m_tail++; end
      m_head = m_head + (PTR_W+1)'(cm);
      cyc();
      dp_num = '0; comnum = '0; dp_dst1_val = 1'b0; dp_dst2_val = 1'b0;
   endtask

   // Model of one walk: pop youngest entries down to tgt, up to max_cyc records.
   task automatic push_walk(input logic [PTR_W:0] tgt, input int max_cyc);
      rec_t r;
      logic [PTR_W:0] p;
      int n;
      n = 0;
      do begin
         r = '{default: '0};
         if (m_tail != tgt) begin
            p = m_tail - 1'b1; r.t1 = m_tag[p[PTR_W-1:0]]; r.v1 = m_val[p[PTR_W-1:0]]; m_tail = p;
         end
         if (m_tail != tgt) begin
            p = m_tail - 1'b1; r.t2 = m_tag[p[PTR_W-1:0]]; r.v2 = m_val[p[PTR_W-1:0]]; m_tail = p;
         end
         sb_q.push_back(r);
         n++;
      end while (m_tail != tgt && n < max_cyc);
   endtask

   task automatic start_walk(input logic [PTR_W:0] ptr);
      prmiss = 1'b1; prmiss_ptr = ptr;
      cyc();
      prmiss = 1'b0;
      chk("walk_start_recovering", 32'(recovering), 32'd1);
   endtask

   task automatic step_check();
      rec_t r;
      cyc();
      if (sb_q.size() == 0) begin
         chk("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
         r = sb_q.pop_front();
         chk("rec_tag1", 32'(rec_tag1), 32'(r.t1));
         chk("rec_tag1_val", 32'(rec_tag1_val), 32'(r.v1));
         chk("rec_tag2", 32'(rec_tag2), 32'(r.t2));
         chk("rec_tag2_val", 32'(rec_tag2_val), 32'(r.v2));
         chk("recovering_during_walk", 32'(recovering), 32'(sb_q.size() != 0));
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && sb_q.size() != 0; i++) step_check();
      chk("walk_timeout_left", 32'(sb_q.size()), 32'd0);
      chk("dp_ptr_after_walk", 32'(dp_ptr), 32'(m_tail));
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin m_tag[i] = '0; m_val[i] = 1'b0; end
      repeat (3) cyc();
      chk("rst_dp_ptr", 32'(dp_ptr), 32'd0);
      chk("rst_recovering", 32'(recovering), 32'd0);
      chk("rst_jfull", 32'(jfull), 32'd0);
      chk("rst_rec_val", 32'({rec_tag1_val, rec_tag2_val}), 32'd0);
      chk("rst_rec_tags", 32'({rec_tag1, rec_tag2}), 32'd0);
      reset = 1'b1;
      cyc();

      // Fill entries 0-7 with tags 8-15.
      for (int i = 0; i < 4; i++) disp(2, 6'(8 + 2*i), 1'b1, 6'(9 + 2*i), 1'b1, 0);
      chk("fill_dp_ptr", 32'(dp_ptr), 32'd8);
      chk("fill_recovering", 32'(recovering), 32'd0);
      chk("fill_jfull", 32'(jfull), 32'd0);

      // Squash behind branch at 3: (15,14) then (13,12).
      push_walk(6'd4, 100);
      start_walk(6'd3);
      drain();

      // Entry 4 = tag 12 with val 0; branch at 1.
      disp(1, 6'd12, 1'b0, 6'd0, 1'b0, 0);
      push_walk(6'd2, 100);
      start_walk(6'd1);
      drain();

      // Empty squash: branch is the youngest entry.
      push_walk(6'd2, 100);
      start_walk(6'd1);
      drain();

      // Older branch arrives mid-walk and retargets it.
      for (int i = 0; i < 4; i++) disp(2, 6'(20 + 2*i), 1'b1, 6'(21 + 2*i), 1'b1, 0);
      push_walk(6'd6, 1);
      push_walk(6'd3, 100);
      start_walk(6'd5);
      prmiss = 1'b1; prmiss_ptr = 6'd2;
      step_check();
      prmiss = 1'b0;
      drain();

      // Non-older branch mid-walk is ignored.
      for (int i = 0; i < 3; i++) disp(2, 6'(30 + 2*i), 1'b1, 6'(31 + 2*i), 1'b1, 0);
      disp(1, 6'd36, 1'b1, 6'd0, 1'b0, 0);
      chk("ign_setup_dp_ptr", 32'(dp_ptr), 32'd10);
      push_walk(6'd6, 100);
      start_walk(6'd5);
      prmiss = 1'b1; prmiss_ptr = 6'd5;
      step_check();
      prmiss = 1'b0;
      drain();

      // Advance to head=30, tail=34 across the index wrap.
      for (int i = 0; i < 14; i++) disp(2, 6'(32 + 2*i), 1'b1, 6'(33 + 2*i), 1'b1, 2);
      disp(0, 6'd0, 1'b0, 6'd0, 1'b0, 2);
      chk("wrap_dp_ptr", 32'(dp_ptr), 32'd34);
      chk("wrap_jfull", 32'(jfull), 32'd0);
      push_walk(6'd32, 100);
      start_walk(6'd31);
      drain();

      // jfull boundary: cnt 30 -> 0, cnt 31 -> 1, back to 29 -> 0.
      for (int i = 0; i < 14; i++) disp(2, 6'(2*i), 1'b1, 6'(2*i + 1), 1'b1, 0);
      chk("jfull_cnt30", 32'(jfull), 32'd0);
      disp(1, 6'd50, 1'b1, 6'd0, 1'b0, 0);
      chk("jfull_cnt31", 32'(jfull), 32'd1);
      disp(0, 6'd0, 1'b0, 6'd0, 1'b0, 2);
      chk("jfull_cnt29", 32'(jfull), 32'd0);

      // Reset in the middle of a long walk.
      push_walk(m_head + 1'b1, 3);
      start_walk(m_head);
      step_check();
      step_check();
      #2 reset = 1'b0;
      #1;
      chk("midrst_outputs", 32'({dp_ptr, rec_tag1, rec_tag2, rec_tag1_val, rec_tag2_val, recovering, jfull}), 32'd0);
      sb_q.delete();
      m_head = '0; m_tail = '0;
      for (int i = 0; i < DEPTH; i++) m_val[i] = 1'b0;
      cyc();
      reset = 1'b1;
      disp(2, 6'd40, 1'b1, 6'd41, 1'b1, 0);
      chk("post_rst_dp_ptr", 32'(dp_ptr), 32'd2);
      push_walk(6'd1, 100);
      start_walk(6'd0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
